// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, HALT opcode field and the
// fetch-stage state encoding.
package mips_pkg;

  localparam int NBITS = 32;
  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if_id.sv
// IF/ID pipeline register: instruction, PC+1 and valid, with load enable and a
// valid-only clear used for squash while the stage is not advancing.
module if_id_reg
  import mips_pkg::*;
#(
  parameter int NBITS = mips_pkg::NBITS
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [NBITS-1:0] i_instr,
  input  logic [NBITS-1:0] i_pc_plus1,
  input  logic             i_valid,
  output logic [NBITS-1:0] o_instr,
  output logic [NBITS-1:0] o_pc_plus1,
  output logic             o_valid
);

  logic [NBITS-1:0] instr_q, instr_d;
  logic [NBITS-1:0] pc_plus1_q, pc_plus1_d;
  logic             valid_q, valid_d;

  // NOTE: every always_comb output gets a hold default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    if (i_load) begin
      instr_d    = i_instr;
      pc_plus1_d = i_pc_plus1;
      valid_d    = i_valid;
    end else if (i_clear) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      instr_q    <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
    end
  end

  assign o_instr    = instr_q;
  assign o_pc_plus1 = pc_plus1_q;
  assign o_valid    = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: drives imem address, next PC, IF/ID register and
// HALT detection. Optional single-step gating is compiled in with IF_STEP_EN.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter int         NBITS       = mips_pkg::NBITS,
  parameter int         ADDR_W      = 10,
  parameter logic [5:0] HALT_OPCODE = mips_pkg::HALT_OPCODE
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_branch_taken,
  input  logic [NBITS-1:0]  i_branch_target,
  input  logic [NBITS-1:0]  i_pc,
`ifdef IF_STEP_EN
  input  logic              i_step_mode,
  input  logic              i_step,
`endif
  output logic [NBITS-1:0]  o_next_pc,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [NBITS-1:0]  i_imem_data,
  output logic [NBITS-1:0]  o_instr,
  output logic [NBITS-1:0]  o_pc_plus1,
  output logic              o_valid,
  output logic              o_halt
);

  fetch_state_e     state_q, state_d;
  logic [NBITS-1:0] r_pc_q, r_pc_d;
  logic             r_req_valid_q, r_req_valid_d;
  logic             halt_q, halt_d;

  logic             step_ok;
  logic             adv;
  logic             capture_halt;
  logic             ifid_load, ifid_clear, ifid_valid_in;

`ifdef IF_STEP_EN
  assign step_ok = ~i_step_mode | i_step;
`else
  assign step_ok = 1'b1;
`endif

  assign adv = i_enable & ~i_stall & (state_q != HALTED) & step_ok;

  // A HALT is only honoured for a live, unsquashed word being captured in RUN.
  assign capture_halt = adv & (state_q == RUN) & r_req_valid_q & ~i_flush &
                        (i_imem_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);

  // Stall/halt do not alter this: the PC register compensates on its own side.
  assign o_next_pc   = i_branch_taken ? i_branch_target : i_pc + NBITS'(1);
  assign o_imem_addr = i_pc[ADDR_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= FILL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (adv)          state_d = RUN;
      RUN:     if (capture_halt) state_d = HALTED;
      HALTED:                    state_d = HALTED;
      default:                   state_d = FILL;
    endcase
  end

  always_comb begin
    ifid_load     = adv;
    ifid_valid_in = (state_q == RUN) & r_req_valid_q & ~i_flush;
    ifid_clear    = (state_q == HALTED) | (~adv & i_flush);
    r_pc_d        = r_pc_q;
    r_req_valid_d = r_req_valid_q;
    halt_d        = halt_q | capture_halt;
    if (adv) begin
      r_pc_d        = i_pc;
      r_req_valid_d = ~i_flush;
    end else if ((state_q != HALTED) && i_flush) begin
      r_req_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc_q        <= '0;
      r_req_valid_q <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      r_pc_q        <= r_pc_d;
      r_req_valid_q <= r_req_valid_d;
      halt_q        <= halt_d;
    end
  end

  assign o_halt = halt_q;

  if_id_reg #(
    .NBITS (NBITS)
  ) u_if_id (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (ifid_load),
    .i_clear    (ifid_clear),
    .i_instr    (i_imem_data),
    .i_pc_plus1 (r_pc_q + NBITS'(1)),
    .i_valid    (ifid_valid_in),
    .o_instr    (o_instr),
    .o_pc_plus1 (o_pc_plus1),
    .o_valid    (o_valid)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed steps then randomized traffic, checked
// against a transaction-level model of fetch requests and IF/ID slots.
module tb_if_fetch_stage;

  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  logic        i_clk = 1'b0;
  logic        i_reset, i_enable, i_stall, i_flush, i_branch_taken;
  logic [31:0] i_branch_target, i_pc, o_next_pc, i_imem_data, o_instr, o_pc_plus1;
  logic [9:0]  o_imem_addr;
  logic        o_valid, o_halt;
`ifdef IF_STEP_EN
  logic        i_step_mode = 1'b0;
  logic        i_step = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  if_fetch_stage dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_stall         (i_stall),
    .i_flush         (i_flush),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_pc            (i_pc),
`ifdef IF_STEP_EN
    .i_step_mode     (i_step_mode),
    .i_step          (i_step),
`endif
    .o_next_pc       (o_next_pc),
    .o_imem_addr     (o_imem_addr),
    .i_imem_data     (i_imem_data),
    .o_instr         (o_instr),
    .o_pc_plus1      (o_pc_plus1),
    .o_valid         (o_valid),
    .o_halt          (o_halt)
  );

  // Synchronous instruction memory; its read port holds while fetch is stalled.
  logic [31:0] mem [1024];
  logic [9:0]  mem_addr_q;
  always @(posedge i_clk) if (i_enable && !i_stall) mem_addr_q <= o_imem_addr;
  assign i_imem_data = mem[mem_addr_q];

  // Reference model: one outstanding fetch request and one IF/ID slot.
  bit          m_req_live, m_out_valid, m_halted;
  logic [31:0] m_req_pc, m_out_instr, m_out_pc1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (i_reset) begin
      m_req_live = 0; m_req_pc = '0; m_out_valid = 0;
      m_out_instr = '0; m_out_pc1 = '0; m_halted = 0;
    end else if (m_halted) begin
      m_out_valid = 0;
    end else if (i_enable && !i_stall) begin
      m_out_valid = m_req_live && !i_flush;
      m_out_instr = mem[m_req_pc[9:0]];
      m_out_pc1   = m_req_pc + 32'd1;
      if (m_out_valid && m_out_instr[31:26] == 6'h3F) m_halted = 1;
      m_req_live = !i_flush;
      m_req_pc   = i_pc;
    end else if (i_flush) begin
      m_out_valid = 0;
      m_req_live  = 0;
    end
  endtask

  // One clock: check combinational outputs, advance model, check IF/ID state.
  task automatic cycle();
    logic [31:0] exp_next;
    bit          moved;
    #1;
    exp_next = i_branch_taken ? i_branch_target : i_pc + 32'd1;
    check("next_pc", o_next_pc, exp_next);
    check("imem_addr", {22'b0, o_imem_addr}, {22'b0, i_pc[9:0]});
    moved = !i_reset && i_enable && !i_stall && !m_halted;
    model_edge();
    @(negedge i_clk);
    if (i_reset) i_pc = '0;
    else if (moved) i_pc = exp_next;
    check("valid", {31'b0, o_valid}, {31'b0, m_out_valid});
    check("halt", {31'b0, o_halt}, {31'b0, m_halted});
    if (m_out_valid || m_halted) begin
      check("instr", o_instr, m_out_instr);
      check("pc_plus1", o_pc_plus1, m_out_pc1);
    end
  endtask

  task automatic do_reset();
    i_reset = 1; i_enable = 1; i_stall = 0; i_flush = 0;
    i_branch_taken = 0; i_branch_target = '0; i_pc = '0;
    cycle(); cycle();
    i_reset = 0;
    check("rst_instr", o_instr, 32'd0);
    check("rst_pc_plus1", o_pc_plus1, 32'd0);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_halt", {31'b0, o_halt}, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = k;
    @(negedge i_clk);

    // Straight-line fetch: first valid word two cycles after PC 0.
    do_reset();
    cycle();
    check("fill_valid", {31'b0, o_valid}, 32'd0);
    cycle();
    check("first_valid", {31'b0, o_valid}, 32'd1);
    check("first_instr", o_instr, 32'd0);
    check("first_pc1", o_pc_plus1, 32'd1);
    cycle();
    check("second_instr", o_instr, 32'd1);
    check("second_pc1", o_pc_plus1, 32'd2);
    repeat (4) cycle();

    // Three-cycle stall mid-stream.
    i_stall = 1;
    repeat (3) cycle();
    i_stall = 0;
    repeat (4) cycle();

    // Branch to 0x40 with flush: two empty slots, then mem[0x40].
    i_branch_taken = 1; i_branch_target = 32'h40; i_flush = 1;
    #1 check("branch_next_pc", o_next_pc, 32'h40);
    cycle();
    i_branch_taken = 0; i_flush = 0;
    check("flush_slot1", {31'b0, o_valid}, 32'd0);
    cycle();
    check("flush_slot2", {31'b0, o_valid}, 32'd0);
    cycle();
    check("target_instr", o_instr, 32'h40);
    check("target_pc1", o_pc_plus1, 32'h41);
    repeat (3) cycle();

    // HALT word at address 5: sticky halt, frozen stage, flush ignored.
    mem[5] = HALT_WORD;
    do_reset();
    for (int n = 0; n < 20 && !o_halt; n++) cycle();
    check("halt_seen", {31'b0, o_halt}, 32'd1);
    check("halt_valid", {31'b0, o_valid}, 32'd1);
    check("halt_instr", o_instr, HALT_WORD);
    for (int n = 0; n < 20; n++) begin
      i_flush = n[2];
      cycle();
    end
    i_flush = 0;
    check("halt_frozen_valid", {31'b0, o_valid}, 32'd0);
    check("halt_frozen_instr", o_instr, HALT_WORD);
    do_reset();
    check("halt_cleared", {31'b0, o_halt}, 32'd0);

    // HALT word squashed in its capture cycle.
    for (int n = 0; n < 20 && i_pc != 32'd6; n++) cycle();
    check("reach_pc6", i_pc, 32'd6);
    i_flush = 1;
    cycle();
    i_flush = 0;
    check("flushed_halt_valid", {31'b0, o_valid}, 32'd0);
    repeat (6) cycle();
    check("flushed_halt_no_halt", {31'b0, o_halt}, 32'd0);

    // PC wrap-around and address truncation.
    i_pc = 32'hFFFF_FFFF;
    #1;
    check("wrap_next_pc", o_next_pc, 32'd0);
    check("wrap_imem_addr", {22'b0, o_imem_addr}, 32'h3FF);
    cycle();
    repeat (3) cycle();

    // Randomized traffic; the last segment seeds HALT words.
    for (int seg = 0; seg < 3; seg++) begin
      for (int k = 0; k < 1024; k++)
        mem[k] = {6'($urandom_range(0, 62)), 26'($urandom)};
      if (seg == 2)
        for (int h = 0; h < 4; h++) mem[$urandom_range(8, 200)] = HALT_WORD | 32'($urandom_range(0, 255));
      do_reset();
      for (int n = 0; n < 300; n++) begin
        i_enable = ($urandom_range(0, 9) != 0);
        i_stall  = ($urandom_range(0, 4) == 0);
        i_branch_taken = ($urandom_range(0, 11) == 0);
        i_branch_target = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
        i_flush = i_branch_taken || ($urandom_range(0, 29) == 0);
        cycle();
      end
      i_enable = 1; i_stall = 0; i_branch_taken = 0; i_flush = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage for the MIPS pipeline. It is the consumer side of the PC register.
- Takes the current PC and drives the synchronous instruction memory read address.
- Computes the next-PC value fed back into the PC register.
- Captures fetched words into the IF/ID pipeline register.
- Detects the HALT instruction and freezes fetch until reset.

Parameters:
NBITS, 32, PC and instruction width
ADDR_W, 10, instruction memory address width (word addressed)
HALT_OPCODE, 6'b111111, opcode field value that halts the core

Ports:
i_clk  in  1  clock
i_reset  in  1  reset, synchronous, active-high
i_enable  in  1  global run enable from debug unit
i_stall  in  1  hazard stall: hold IF/ID and in-flight request
i_flush  in  1  squash in-flight and captured instruction (branch resolved)
i_branch_taken  in  1  select i_branch_target as next PC
i_branch_target  in  NBITS  branch/jump target (word address)
i_pc  in  NBITS  current PC from PC register
o_next_pc  out  NBITS  next PC fed to PC register
o_imem_addr  out  ADDR_W  instruction memory read address
i_imem_data  in  NBITS  memory read data, valid 1 cycle after address
o_instr  out  NBITS  IF/ID instruction
o_pc_plus1  out  NBITS  IF/ID PC+1 of o_instr
o_valid  out  1  IF/ID holds a real instruction
o_halt  out  1  HALT reached, sticky until reset

Behaviour:
- Reset (synchronous): o_instr=0, o_pc_plus1=0, o_valid=0, o_halt=0, r_pc_q=0, r_req_valid=0, state=FILL.
- o_imem_addr = i_pc[ADDR_W-1:0], combinational. Upper PC bits are ignored.
- o_next_pc is combinational: i_branch_taken ? i_branch_target : i_pc+1, computed mod 2^NBITS (all-ones wraps to 0).
- During stall and halt, o_next_pc keeps the same formula. The PC register's own decrement on stall/halt yields a held PC; this block does not compensate.
- Advance condition: adv = i_enable & !i_stall & state!=HALTED.
- On adv:
  - r_pc_q<=i_pc.
  - r_req_valid<=!i_flush.
  - o_instr<=i_imem_data.
  - o_pc_plus1<=r_pc_q+1.
  - o_valid<=r_req_valid & !i_flush.
- Latency: PC to IF/ID output is 2 cycles.
- !adv: all registers hold. Exception: i_flush still clears o_valid and r_req_valid when the state is not HALTED.
- State machine:
  - FILL -> RUN on the first adv cycle. o_valid stays 0 during FILL.
  - RUN -> HALTED on adv when r_req_valid & !i_flush & i_imem_data[31:26]==HALT_OPCODE.
  - On entry to HALTED: o_instr<=HALT word, o_valid<=1 for one cycle, o_halt<=1.
  - In HALTED: o_valid cleared the next cycle; o_halt stays high; registers frozen; i_flush ignored.
  - HALTED exits only on i_reset.
- Simultaneous events:
  - flush+halt word: flush wins, no halt.
  - stall+flush: flush clears valid, all other registers hold.
  - reset wins over everything.
- Reset mid-fetch discards the in-flight word.

Optional Feature:
IF_STEP_EN
- Defined: adds ports i_step_mode (1) and i_step (1). While i_step_mode=1, adv additionally requires i_step, so exactly one instruction is fetched per one-cycle i_step pulse. i_step held high for multiple cycles counts as multiple steps.
- Undefined: these ports do not exist and adv is as above.

Decomposition:
- Shared package mips_pkg holds:
  - NBITS
  - HALT_OPCODE
  - OPCODE_MSB=31, OPCODE_LSB=26
  - fetch state encoding FILL/RUN/HALTED
- One sub-module is natural: if_id_reg, the instruction/pc_plus1/valid register with enable and flush.

Test Plan:
- Reset, enable=1, memory loaded with word k at address k, PC counting from 0 -> o_valid rises on cycle 2 with o_instr=mem[0], o_pc_plus1=1; mem[1] with o_pc_plus1=2 the next cycle.
- Stall held 3 cycles mid-stream -> o_instr/o_pc_plus1/o_valid unchanged for all 3 cycles; no instruction skipped or duplicated afterwards.
- i_branch_taken=1, target=0x40, i_flush pulse -> o_next_pc=0x40 that cycle; the next two IF/ID slots have o_valid=0; mem[0x40] appears afterwards.
- HALT word (0xFC000000) at address 5 -> o_halt=1 with o_instr=0xFC000000 valid one cycle; o_valid=0 after; state frozen for 20 cycles; reset clears o_halt.
- HALT word fetched with i_flush in its capture cycle -> o_halt stays 0, o_valid=0.
- i_pc=0xFFFFFFFF, no branch -> o_next_pc=0x00000000; o_imem_addr=0x3FF.
